pe_mac_unit: RTL and testbench

//  Parametrised multi-lane processing element for the convolution coprocessor.

---
 rtl/pe_mac_unit.sv | 127 ++++++++++++
 tb/tb_pe_mac_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pe_mac_unit.sv
// Multi-lane MAC processing element: one registered dot-product stage feeding
// a saturating accumulator, with the result returned over a valid/ready handshake.
module pe_mac_lane #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0]   i_a,
  input  logic [DATA_W-1:0]   i_b,
  output logic [2*DATA_W-1:0] o_p
);
  assign o_p = $signed(i_a) * $signed(i_b);
endmodule

module pe_mac_unit #(
  parameter int DATA_W = 16,
  parameter int LANES  = 4,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [LEN_W-1:0]        len_i,
  input  logic [ACC_W-1:0]        bias_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*DATA_W-1:0] a_i,
  input  logic [LANES*DATA_W-1:0] b_i,
  output logic [ACC_W-1:0]        result_o,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic                    pe_finished_o
);
  localparam int PW = 2*DATA_W + $clog2(LANES);
  localparam int SW = ((PW > ACC_W) ? PW : ACC_W) + 1;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic [LEN_W-1:0]         r_len, r_cnt;
  logic [ACC_W-1:0]         r_acc;
  logic [PW-1:0]            r_p;
  logic                     r_pv;
  logic                     r_ovf;

  logic [LANES-1:0][2*DATA_W-1:0] w_prod;
  logic signed [PW-1:0]     w_dot;
  logic signed [SW-1:0]     w_sum;
  logic [ACC_W-1:0]         w_sat;
  logic                     w_sat_hit;
  logic                     w_start, w_beat, w_last;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pe_mac_lane #(.DATA_W(DATA_W)) u_lane (
      .i_a (a_i[k*DATA_W +: DATA_W]),
      .i_b (b_i[k*DATA_W +: DATA_W]),
      .o_p (w_prod[k])
    );
  end

  always_comb begin
    w_dot = '0;
    for (int k = 0; k < LANES; k++)
      w_dot = w_dot + PW'($signed(w_prod[k]));
  end

  // Sum is wide enough that it can never wrap; it fits ACC_W iff its top bits agree.
  always_comb begin
    w_sum     = $signed({{(SW-ACC_W){r_acc[ACC_W-1]}}, r_acc})
              + $signed({{(SW-PW){r_p[PW-1]}}, r_p});
    w_sat_hit = !((&w_sum[SW-1:ACC_W-1]) || !(|w_sum[SW-1:ACC_W-1]));
    w_sat     = w_sum[ACC_W-1:0];
    if (w_sat_hit)
      w_sat = w_sum[SW-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end

  assign w_start = (r_state == IDLE) && start_i;
  assign w_beat  = (r_state == ACC) && in_valid_i;
  assign w_last  = w_beat && (r_cnt == r_len - 1'b1);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start_i) w_state_nxt = (len_i == '0) ? DONE : ACC;
      ACC:     if (w_last) w_state_nxt = DRAIN;
      DRAIN:   w_state_nxt = DONE;
      DONE:    if (result_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_p     <= '0;
      r_pv    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pv    <= w_beat;
      if (w_beat) r_p <= w_dot;
      if (w_start) begin
        r_len <= len_i;
        r_cnt <= '0;
        r_acc <= bias_i;
        r_ovf <= 1'b0;
      end else begin
        if (w_beat) r_cnt <= r_cnt + 1'b1;
        if (r_pv) begin
          r_acc <= w_sat;
          if (w_sat_hit) r_ovf <= 1'b1;
        end
      end
    end
  end

  assign in_ready_o     = (r_state == ACC);
  assign result_o       = r_acc;
  assign result_valid_o = (r_state == DONE);
  assign busy_o         = (r_state != IDLE);
  assign overflow_o     = r_ovf;
  assign pe_finished_o  = (r_state == DONE) && result_ready_i;
endmodule

// File: tb/tb_pe_mac_unit.sv
// Directed bench for pe_mac_unit: table of whole jobs plus hand-written
// sequences for back-pressure, clamp continuation and mid-job reset.
module tb_pe_mac_unit;
  logic        clk = 1'b0;
  logic        rst_i, start_i, in_valid_i, result_ready_i;
  logic [7:0]  len_i;
  logic [31:0] bias_i;
  logic [63:0] a_i, b_i;
  logic        in_ready_o, result_valid_o, busy_o, overflow_o, pe_finished_o;
  logic [31:0] result_o;

  int checks = 0;
  int failures = 0;

  pe_mac_unit dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .bias_i(bias_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .a_i(a_i), .b_i(b_i),
    .result_o(result_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .busy_o(busy_o), .overflow_o(overflow_o), .pe_finished_o(pe_finished_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  len;
    logic [31:0] bias;
    logic [63:0] a;
    logic [63:0] b;
    logic        gaps;
    logic [31:0] exp_res;
    logic        exp_ovf;
    string       name;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [63:0] pack4(int l0, int l1, int l2, int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(logic [7:0] len, logic [31:0] bias);
    start_i = 1'b1; len_i = len; bias_i = bias;
    tick();
    start_i = 1'b0; len_i = '0; bias_i = '0;
  endtask

  task automatic beat(logic [63:0] a, logic [63:0] b, string nm);
    in_valid_i = 1'b1; a_i = a; b_i = b;
    if (!in_ready_o) chk({nm, "_in_ready"}, {31'b0, in_ready_o}, 32'd1);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done(int exp_cyc, string nm);
    int cyc = 0;
    while (!result_valid_o && cyc < 10) begin
      tick();
      cyc++;
    end
    chk({nm, "_latency"}, 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic handshake(string nm);
    result_ready_i = 1'b1;
    #1;
    chk({nm, "_finished_pulse"}, {31'b0, pe_finished_o}, 32'd1);
    tick();
    result_ready_i = 1'b0;
    #1;
    chk({nm, "_idle_busy"}, {31'b0, busy_o}, 32'd0);
    chk({nm, "_finished_low"}, {31'b0, pe_finished_o}, 32'd0);
  endtask

  task automatic run_vec(vec_t v);
    start_job(v.len, v.bias);
    chk({v.name, "_busy"}, {31'b0, busy_o}, 32'd1);
    chk({v.name, "_ovf_cleared"}, {31'b0, overflow_o}, 32'd0);
    chk({v.name, "_acc_bias"}, result_o, v.bias);
    for (int i = 0; i < int'(v.len); i++) begin
      if (v.gaps && i > 0) tick();
      beat(v.a, v.b, v.name);
    end
    in_valid_i = 1'b1;  // must be ignored after the last beat
    wait_done((v.len == 0) ? 0 : 1, v.name);
    chk({v.name, "_result"}, result_o, v.exp_res);
    chk({v.name, "_ovf"}, {31'b0, overflow_o}, {31'b0, v.exp_ovf});
    chk({v.name, "_ready_low"}, {31'b0, in_ready_o}, 32'd0);
    in_valid_i = 1'b0;
    handshake(v.name);
  endtask

  initial begin
    vecs[0] = '{8'd1, 32'd10, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0, 32'd80, 1'b0, "t1_basic"};
    vecs[1] = '{8'd0, 32'hFFFF_FFF9, '0, '0, 1'b0, 32'hFFFF_FFF9, 1'b0, "t2_len0"};
    vecs[2] = '{8'd3, 32'd0, pack4(2, 2, 2, 2), pack4(2, 2, 2, 2), 1'b1, 32'd48, 1'b0, "t3_gaps"};
    vecs[3] = '{8'd1, 32'h7FFF_FFF0, pack4(100, 100, 100, 100), pack4(100, 100, 100, 100),
                1'b0, 32'h7FFF_FFFF, 1'b1, "t4_pos_sat"};
    vecs[4] = '{8'd2, 32'hFFFF_FFFB, pack4(-3, 4, -5, 6), pack4(7, -8, 9, 10),
                1'b0, 32'hFFFF_FFAF, 1'b0, "mixed_signs"};
    vecs[5] = '{8'd1, 32'h8000_0010, pack4(-32768, -32768, -32768, -32768),
                pack4(32767, 32767, 32767, 32767), 1'b0, 32'h8000_0000, 1'b1, "neg_sat"};
    vecs[6] = '{8'd1, 32'h8000_0000, pack4(-32768, -32768, 0, 0), pack4(-32768, -32768, 0, 0),
                1'b0, 32'd0, 1'b0, "wide_sum"};
    vecs[7] = '{8'd255, 32'd0, pack4(1, 0, 0, 0), pack4(1, 0, 0, 0), 1'b0, 32'd255, 1'b0, "len_max"};

    rst_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; result_ready_i = 1'b0;
    len_i = '0; bias_i = '0; a_i = '0; b_i = '0;
    tick(); tick();
    chk("rst_result", result_o, 32'd0);
    chk("rst_valid", {31'b0, result_valid_o}, 32'd0);
    chk("rst_busy", {31'b0, busy_o}, 32'd0);
    chk("rst_ovf", {31'b0, overflow_o}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready_o}, 32'd0);
    chk("rst_finished", {31'b0, pe_finished_o}, 32'd0);
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Result held under back-pressure; start_i during DONE and on the handshake is dropped.
    start_job(8'd1, 32'd3);
    beat(pack4(1, 1, 1, 1), pack4(1, 1, 1, 1), "t5");
    wait_done(1, "t5");
    for (int i = 0; i < 5; i++) begin
      start_i = 1'b1; len_i = 8'd0; bias_i = 32'd99;
      tick();
      chk("t5_stable_result", result_o, 32'd7);
      chk("t5_stable_valid", {31'b0, result_valid_o}, 32'd1);
      chk("t5_no_finish", {31'b0, pe_finished_o}, 32'd0);
    end
    handshake("t5");
    start_i = 1'b0;
    tick();
    chk("t5_start_not_taken", {31'b0, busy_o}, 32'd0);

    // Accumulation carries on from the clamped value.
    start_job(8'd2, 32'h7FFF_FFF0);
    beat(pack4(100, 100, 100, 100), pack4(100, 100, 100, 100), "clamp");
    beat(pack4(-1, 0, 0, 0), pack4(1, 0, 0, 0), "clamp");
    wait_done(1, "clamp");
    chk("clamp_continue", result_o, 32'h7FFF_FFFE);
    chk("clamp_ovf", {31'b0, overflow_o}, 32'd1);
    handshake("clamp");

    // Reset in the middle of a job.
    start_job(8'd4, 32'h7FFF_FFF0);
    beat(pack4(100, 100, 100, 100), pack4(100, 100, 100, 100), "t6");
    beat(pack4(100, 100, 100, 100), pack4(100, 100, 100, 100), "t6");
    tick();
    chk("t6_ovf_before_rst", {31'b0, overflow_o}, 32'd1);
    rst_i = 1'b1; in_valid_i = 1'b1; result_ready_i = 1'b1;
    tick();
    chk("t6_rst_result", result_o, 32'd0);
    chk("t6_rst_valid", {31'b0, result_valid_o}, 32'd0);
    chk("t6_rst_busy", {31'b0, busy_o}, 32'd0);
    chk("t6_rst_ovf", {31'b0, overflow_o}, 32'd0);
    chk("t6_rst_in_ready", {31'b0, in_ready_o}, 32'd0);
    chk("t6_rst_finished", {31'b0, pe_finished_o}, 32'd0);
    rst_i = 1'b0; in_valid_i = 1'b0; result_ready_i = 1'b0;
    tick();
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
